mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch side and the data (LD/LDR/ST/STR) side of the RISC_TOY pipeline.
- Arbitrates requests and issues one outstanding transaction at a time on the memory port.
- Routes read data or write completion back to the owning side.
- Data side normally wins; a starvation limit guarantees fetch progress, and a timeout guarantees forward progress.

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and data (D) sides.
// One outstanding transaction at a time; D normally wins, a starvation limit protects I.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT_CYC  = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        I_REQ,
   input  logic [29:0] I_ADDR,
   output logic        I_GNT,
   output logic        I_RVALID,
   output logic [31:0] I_RDATA,
   input  logic        D_REQ,
   input  logic        D_RW,
   input  logic [29:0] D_ADDR,
   input  logic [31:0] D_WDATA,
   output logic        D_GNT,
   output logic        D_RVALID,
   output logic [31:0] D_RDATA,
   output logic        M_REQ,
   output logic        M_RW,
   output logic [29:0] M_ADDR,
   output logic [31:0] M_WDATA,
   input  logic        M_ACK,
   input  logic        M_RVALID,
   input  logic [31:0] M_RDATA,
   output logic        BUSY,
   output logic        ERR
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]    state_reg,  state_next;
   logic          owner_reg,  owner_next;   // 1 = data side, 0 = fetch side
   logic          rw_reg,     rw_next;
   logic [29:0]   addr_reg,   addr_next;
   logic [31:0]   wdata_reg,  wdata_next;
   logic [SW-1:0] streak_reg, streak_next;
   logic [TW-1:0] timer_reg,  timer_next;
   logic [1:0]    gnt_reg,    gnt_next;     // index 0 = I, 1 = D
   logic [1:0]    rvalid_reg, rvalid_next;
   logic          err_reg,    err_next;
   logic          rdata_load_next;
   logic [31:0]   rdata_next;
   logic          pick_d;
   logic          timeout;

   assign pick_d  = D_REQ && !(I_REQ && (streak_reg == STREAK_MAX));
   assign timeout = (timer_reg == TIMER_LAST);

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      rw_next         = rw_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      streak_next     = streak_reg;
      timer_next      = timer_reg;
      gnt_next        = 2'b00;
      rvalid_next     = 2'b00;
      err_next        = 1'b0;
      rdata_load_next = 1'b0;
      rdata_next      = 32'd0;
      case (state_reg)
         ST_IDLE: begin
            if (pick_d) begin
               owner_next  = 1'b1;
               rw_next     = D_RW;
               addr_next   = D_ADDR;
               wdata_next  = D_WDATA;
               gnt_next[1] = 1'b1;
               state_next  = ST_REQ;
               timer_next  = '0;
               if (!I_REQ)
                  streak_next = '0;
               else if (streak_reg != STREAK_MAX)
                  streak_next = streak_reg + 1'b1;
            end else if (I_REQ) begin
               owner_next  = 1'b0;
               rw_next     = 1'b0;
               addr_next   = I_ADDR;
               wdata_next  = 32'd0;
               gnt_next[0] = 1'b1;
               state_next  = ST_REQ;
               timer_next  = '0;
               streak_next = '0;
            end
         end
         ST_REQ: begin
            timer_next = timer_reg + 1'b1;
            if (M_ACK && rw_reg) begin
               rvalid_next[owner_reg] = 1'b1;
               rdata_load_next        = 1'b1;
               state_next             = ST_IDLE;
            end else if (timeout) begin
               err_next               = 1'b1;
               rvalid_next[owner_reg] = 1'b1;
               rdata_load_next        = 1'b1;
               state_next             = ST_IDLE;
            end else if (M_ACK) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            timer_next = timer_reg + 1'b1;
            if (M_RVALID) begin
               rvalid_next[owner_reg] = 1'b1;
               rdata_load_next        = 1'b1;
               rdata_next             = M_RDATA;
               state_next             = ST_IDLE;
            end else if (timeout) begin
               err_next               = 1'b1;
               rvalid_next[owner_reg] = 1'b1;
               rdata_load_next        = 1'b1;
               state_next             = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg  <= ST_IDLE;
         owner_reg  <= 1'b0;
         rw_reg     <= 1'b0;
         addr_reg   <= 30'd0;
         wdata_reg  <= 32'd0;
         streak_reg <= '0;
         timer_reg  <= '0;
         gnt_reg    <= 2'b00;
         rvalid_reg <= 2'b00;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         rw_reg     <= rw_next;
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
         streak_reg <= streak_next;
         timer_reg  <= timer_next;
         gnt_reg    <= gnt_next;
         rvalid_reg <= rvalid_next;
         err_reg    <= err_next;
      end
   end

   // Each side keeps its last read result until its own next completion.
   for (genvar gi = 0; gi < 2; gi++) begin : g_side
      localparam logic SIDE = (gi == 1);
      logic [31:0] rdata_reg;
      always_ff @(posedge CLK) begin
         if (RST)
            rdata_reg <= 32'd0;
         else if (rdata_load_next && (owner_reg == SIDE))
            rdata_reg <= rdata_next;
      end
   end

   assign I_GNT    = gnt_reg[0];
   assign D_GNT    = gnt_reg[1];
   assign I_RVALID = rvalid_reg[0];
   assign D_RVALID = rvalid_reg[1];
   assign I_RDATA  = g_side[0].rdata_reg;
   assign D_RDATA  = g_side[1].rdata_reg;
   assign M_REQ    = (state_reg == ST_REQ);
   assign M_RW     = rw_reg;
   assign M_ADDR   = addr_reg;
   assign M_WDATA  = wdata_reg;
   assign BUSY     = (state_reg != ST_IDLE);
   assign ERR      = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, write, contention, timeout,
// stalled accept and reset mid-transaction, with hand-computed expectations.
module tb_mem_port_arbiter;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        I_REQ = 1'b0;
   logic [29:0] I_ADDR = '0;
   logic        I_GNT, I_RVALID;
   logic [31:0] I_RDATA;
   logic        D_REQ = 1'b0;
   logic        D_RW = 1'b0;
   logic [29:0] D_ADDR = '0;
   logic [31:0] D_WDATA = '0;
   logic        D_GNT, D_RVALID;
   logic [31:0] D_RDATA;
   logic        M_REQ, M_RW;
   logic [29:0] M_ADDR;
   logic [31:0] M_WDATA;
   logic        M_ACK = 1'b0;
   logic        M_RVALID = 1'b0;
   logic [31:0] M_RDATA = '0;
   logic        BUSY, ERR;

   int checks = 0;
   int errors = 0;
   int n;
   int both_cnt = 0;
   logic exp_d;

   mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYC(8)) dut (
      .CLK(CLK), .RST(RST),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
      .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
      .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
      .M_ACK(M_ACK), .M_RVALID(M_RVALID), .M_RDATA(M_RDATA),
      .BUSY(BUSY), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (I_RVALID && D_RVALID) both_cnt++;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_fetch(input logic [29:0] a, input logic [31:0] d);
      I_REQ = 1'b1; I_ADDR = a;
      tick();
      chk("f_gnt", 32'(I_GNT), 32'd1);
      chk("f_mreq", 32'(M_REQ), 32'd1);
      chk("f_maddr", 32'(M_ADDR), 32'(a));
      chk("f_mrw", 32'(M_RW), 32'd0);
      chk("f_busy", 32'(BUSY), 32'd1);
      I_REQ = 1'b0; M_ACK = 1'b1;
      tick();
      chk("f_wait_mreq", 32'(M_REQ), 32'd0);
      chk("f_gnt_once", 32'(I_GNT), 32'd0);
      chk("f_rvalid_early", 32'(I_RVALID), 32'd0);
      M_ACK = 1'b0; M_RVALID = 1'b1; M_RDATA = d;
      tick();
      chk("f_rvalid", 32'(I_RVALID), 32'd1);
      chk("f_rdata", I_RDATA, d);
      chk("f_d_rvalid", 32'(D_RVALID), 32'd0);
      M_RVALID = 1'b0;
      tick();
      chk("f_rvalid_pulse", 32'(I_RVALID), 32'd0);
      chk("f_busy_after", 32'(BUSY), 32'd0);
      chk("f_rdata_hold", I_RDATA, d);
      $display("txn fetch addr=%h data=%h", a, I_RDATA);
   endtask

   initial begin
      tick(); tick();
      RST = 1'b0;
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_mreq", 32'(M_REQ), 32'd0);
      chk("rst_gnt", {30'd0, I_GNT, D_GNT}, 32'd0);
      chk("rst_rvalid", {30'd0, I_RVALID, D_RVALID}, 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      chk("rst_maddr", 32'(M_ADDR), 32'd0);
      chk("rst_rdata", I_RDATA | D_RDATA | M_WDATA, 32'd0);

      do_fetch(30'h10, 32'h1234_5678);

      // Zero-wait data write
      D_REQ = 1'b1; D_RW = 1'b1; D_ADDR = 30'h3; D_WDATA = 32'hCAFE;
      tick();
      chk("w_gnt", 32'(D_GNT), 32'd1);
      chk("w_igmt", 32'(I_GNT), 32'd0);
      chk("w_mrw", 32'(M_RW), 32'd1);
      chk("w_maddr", 32'(M_ADDR), 32'h3);
      chk("w_mwdata", M_WDATA, 32'hCAFE);
      D_REQ = 1'b0; M_ACK = 1'b1;
      tick();
      chk("w_rvalid", 32'(D_RVALID), 32'd1);
      chk("w_rdata", D_RDATA, 32'd0);
      chk("w_i_rvalid", 32'(I_RVALID), 32'd0);
      chk("w_i_rdata", I_RDATA, 32'h1234_5678);
      chk("w_busy", 32'(BUSY), 32'd0);
      M_ACK = 1'b0;
      $display("txn write addr=%h data=%h", 30'h3, 32'hCAFE);

      // Contention: both held, memory always ready
      I_REQ = 1'b1; D_REQ = 1'b1; D_RW = 1'b1; I_ADDR = 30'h20; D_ADDR = 30'h30;
      M_ACK = 1'b1; M_RVALID = 1'b1; M_RDATA = 32'hA5A5_0001;
      for (int g = 0; g < 10; g++) begin
         n = 0;
         while (!(I_GNT || D_GNT) && n < 10) begin
            tick();
            n++;
         end
         exp_d = ((g % 5) != 4);
         chk("cont_d_gnt", 32'(D_GNT), 32'(exp_d));
         chk("cont_i_gnt", 32'(I_GNT), 32'(!exp_d));
         $display("txn contention grant %0d: %s", g, D_GNT ? "D" : (I_GNT ? "I" : "none"));
         if (g == 9) begin
            I_REQ = 1'b0; D_REQ = 1'b0;
         end
         tick();
      end
      n = 0;
      while (BUSY && n < 10) begin
         tick();
         n++;
      end
      chk("cont_drain", 32'(BUSY), 32'd0);
      M_ACK = 1'b0; M_RVALID = 1'b0;
      tick();

      // Read completing in the final allowed cycle
      D_REQ = 1'b1; D_RW = 1'b0; D_ADDR = 30'h5;
      tick();
      chk("to1_gnt", 32'(D_GNT), 32'd1);
      D_REQ = 1'b0; M_ACK = 1'b1;
      tick();
      M_ACK = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("to1_busy_last", 32'(BUSY), 32'd1);
      chk("to1_err_early", 32'(ERR), 32'd0);
      M_RVALID = 1'b1; M_RDATA = 32'hDEAD_BEEF;
      tick();
      chk("to1_err", 32'(ERR), 32'd0);
      chk("to1_rvalid", 32'(D_RVALID), 32'd1);
      chk("to1_rdata", D_RDATA, 32'hDEAD_BEEF);
      M_RVALID = 1'b0;
      $display("txn read addr=%h data=%h (last cycle)", 30'h5, D_RDATA);
      tick();

      // Read with no data ever returned: aborts after 8 cycles
      D_REQ = 1'b1; D_RW = 1'b0; D_ADDR = 30'h6;
      tick();
      chk("to2_gnt", 32'(D_GNT), 32'd1);
      D_REQ = 1'b0; M_ACK = 1'b1;
      tick();
      M_ACK = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("to2_busy_last", 32'(BUSY), 32'd1);
      chk("to2_err_early", 32'(ERR), 32'd0);
      chk("to2_rvalid_early", 32'(D_RVALID), 32'd0);
      tick();
      chk("to2_err", 32'(ERR), 32'd1);
      chk("to2_rvalid", 32'(D_RVALID), 32'd1);
      chk("to2_rdata", D_RDATA, 32'd0);
      chk("to2_i_rvalid", 32'(I_RVALID), 32'd0);
      chk("to2_busy", 32'(BUSY), 32'd0);
      $display("txn read addr=%h aborted err=%0d", 30'h6, ERR);
      tick();
      chk("to2_err_pulse", 32'(ERR), 32'd0);
      chk("to2_idle", 32'(BUSY), 32'd0);

      // Stalled accept: request fields stable while D inputs wander
      D_REQ = 1'b1; D_RW = 1'b1; D_ADDR = 30'h2A; D_WDATA = 32'h55AA;
      tick();
      chk("st_gnt", 32'(D_GNT), 32'd1);
      for (int k = 0; k < 5; k++) begin
         chk("st_mreq", 32'(M_REQ), 32'd1);
         chk("st_maddr", 32'(M_ADDR), 32'h2A);
         chk("st_mwdata", M_WDATA, 32'h55AA);
         chk("st_mrw", 32'(M_RW), 32'd1);
         D_REQ = 1'($urandom_range(1, 0)); D_RW = 1'($urandom_range(1, 0));
         D_ADDR = 30'($urandom); D_WDATA = $urandom;
         tick();
      end
      chk("st_maddr_end", 32'(M_ADDR), 32'h2A);
      chk("st_rvalid_early", 32'(D_RVALID), 32'd0);
      D_REQ = 1'b0; M_ACK = 1'b1;
      tick();
      chk("st_rvalid", 32'(D_RVALID), 32'd1);
      chk("st_rdata", D_RDATA, 32'd0);
      chk("st_busy", 32'(BUSY), 32'd0);
      M_ACK = 1'b0;
      $display("txn stalled write addr=%h", 30'h2A);
      tick();

      // Reset while waiting for read data
      I_REQ = 1'b1; I_ADDR = 30'h44;
      tick();
      chk("rm_gnt", 32'(I_GNT), 32'd1);
      I_REQ = 1'b0; M_ACK = 1'b1;
      tick();
      chk("rm_wait", 32'(BUSY), 32'd1);
      M_ACK = 1'b0; RST = 1'b1;
      tick();
      RST = 1'b0; M_RVALID = 1'b1; M_RDATA = 32'h0000_0777;
      chk("rm_busy", 32'(BUSY), 32'd0);
      chk("rm_mreq", 32'(M_REQ), 32'd0);
      chk("rm_maddr", 32'(M_ADDR), 32'd0);
      chk("rm_rdata", I_RDATA | D_RDATA, 32'd0);
      tick();
      chk("rm_rvalid", {30'd0, I_RVALID, D_RVALID}, 32'd0);
      chk("rm_err", 32'(ERR), 32'd0);
      chk("rm_i_rdata", I_RDATA, 32'd0);
      M_RVALID = 1'b0;
      $display("txn fetch addr=%h abandoned by reset", 30'h44);
      tick();

      do_fetch(30'h10, 32'h1234_5678);

      chk("excl_rvalid", 32'(both_cnt), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
